exec_stage: RTL and testbench
=============================

EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the register and operand width.
REQ-002 The block SHALL have parameter AW, default 3, meaning the register-address width (8 registers).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port instr_valid, input, 1 bit: the instruction fields are valid.
REQ-006 The block SHALL have port instr_ready, output, 1 bit: the block accepts an instruction this cycle.
REQ-007 The block SHALL have ports opcode (input, 3 bits), dst (input, AW), src1 (input, AW) and src2 (input, AW): the instruction fields.
REQ-008 The block SHALL have ports addr1 (output, AW), addr2 (output, AW) and rd (output, 1 bit): the register-file read request.
REQ-009 The block SHALL have ports data_out1 (input, DATA_W) and data_out2 (input, DATA_W): the register-file read data, combinational from addr1/addr2 while rd=1.
REQ-010 The block SHALL have ports wr_addr (output, AW), wr (output, 1 bit) and data_in (output, DATA_W): the register-file write-back.
REQ-011 The block SHALL have ports zero (output, 1 bit), carry (output, 1 bit) and busy (output, 1 bit): status flags and a not-idle indication.

Function
REQ-012 The FSM SHALL have states IDLE, READ, EXEC, MUL and WB.
REQ-013 instr_ready SHALL equal (state==IDLE); busy SHALL equal !instr_ready.
REQ-014 An instruction SHALL be accepted on a rising edge where instr_valid=1 and instr_ready=1; opcode, dst, src1 and src2 are latched, and the FSM moves IDLE->READ.
REQ-015 READ: the block SHALL drive rd=1, addr1=src1 and addr2=src2, and SHALL capture data_out1/data_out2 into operand registers A/B at the end of the cycle; next state is EXEC. Outside READ, rd SHALL be 0.
REQ-016 Opcode encoding in EXEC SHALL be:
  - 0 ADD: A+B, carry=carry-out.
  - 1 SUB: A-B, carry=borrow (A<B).
  - 2 AND, 3 OR, 4 XOR: carry=0.
  - 5 MOV: result=A, carry unchanged.
  - 6 MUL: go to MUL.
  - 7 NOP: go to IDLE with no write-back and no flag change.
REQ-017 For all opcodes except 6 and 7, EXEC SHALL go to WB.
REQ-018 MUL SHALL be a shift-add multiply lasting exactly DATA_W cycles, with a 2*DATA_W-bit product.
REQ-019 After MUL completes, result SHALL be the low DATA_W bits of the product, carry SHALL be 1 iff the high half is nonzero, and the next state SHALL be WB.
REQ-020 In WB, wr SHALL be 1 for exactly one cycle, with wr_addr=latched dst and data_in=result.
REQ-021 zero SHALL be (result==0), zero and carry SHALL update on the edge ending WB, and the next state SHALL be IDLE.
REQ-022 Latency SHALL be: accept edge at cycle 0, wr high in cycle 3 (non-MUL) or cycle 3+DATA_W (MUL), and instr_ready high again in the cycle after WB.
REQ-023 Arithmetic SHALL wrap modulo 2^DATA_W.
REQ-024 When dst equals src1 or src2, the block SHALL read the old value; the write lands only in WB.
REQ-025 instr_valid asserted while busy SHALL be ignored, and the fields SHALL NOT be re-latched.
REQ-026 wr, wr_addr and data_in SHALL be 0 outside WB.

Reset
REQ-027 On an rst=1 edge, the FSM SHALL be forced to IDLE, and A, B, result, the product, the MUL counter, zero and carry SHALL be cleared to 0.
REQ-028 After reset, outputs SHALL be: instr_ready=1, busy=0, rd=0, wr=0, and addr1, addr2, wr_addr and data_in all 0.
REQ-029 Reset mid-operation (READ, EXEC, MUL or WB) SHALL abandon the instruction, with no write-back after the reset edge.
REQ-030 rst SHALL have priority over an accept in the same cycle.

Structure
REQ-031 Opcode constants (OP_ADD..OP_NOP) and the state encoding SHALL live in shared package proc_pkg, for reuse by the decoder.
REQ-032 The combinational ALU SHALL be sub-module alu_comb (inputs A, B, opcode; outputs result and carry); the FSM and the multiplier stay in exec_stage.

Verification
REQ-033 Preload R1=200 and R2=100, then issue ADD dst=3, src1=1, src2=2 -> wr in cycle 3 with wr_addr=3 and data_in=44, then carry=1 and zero=0.
REQ-034 Preload R4=5, then issue SUB dst=5, src1=4, src2=4 -> data_in=0, zero=1, carry=0.
REQ-035 Preload R1=16 and R2=20, then issue MUL dst=6 -> wr in cycle 11 with data_in=64 (320 mod 256) and carry=1; instr_ready=0 for cycles 1-11.
REQ-036 Issue NOP -> wr never asserted, flags unchanged, instr_ready high again at cycle 3.
REQ-037 Start MUL, assert rst in cycle 5 -> no wr at any point, instr_ready=1 and flags 0 the cycle after reset.
REQ-038 Hold instr_valid=1 through a busy ADD while changing the fields -> only the first instruction executes; the second is accepted the cycle after WB.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - opcode and execute-FSM state constants shared by decoder and execute stage
package proc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - single-cycle ALU for the non-multiply opcodes
module alu_comb
  import proc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // The extra top bit is the carry-out for ADD and the borrow for SUB.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV: result = a;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - multi-cycle execute stage: register read, ALU or shift-add multiply, write-back
module exec_stage
  import proc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        opcode,
  input  logic [AW-1:0]     dst,
  input  logic [AW-1:0]     src1,
  input  logic [AW-1:0]     src2,
  output logic [AW-1:0]     addr1,
  output logic [AW-1:0]     addr2,
  output logic              rd,
  input  logic [DATA_W-1:0] data_out1,
  input  logic [DATA_W-1:0] data_out2,
  output logic [AW-1:0]     wr_addr,
  output logic              wr,
  output logic [DATA_W-1:0] data_in,
  output logic              zero,
  output logic              carry,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [2:0]          state;
  logic [2:0]          op_q;
  logic [AW-1:0]       dst_q;
  logic [AW-1:0]       src1_q;
  logic [AW-1:0]       src2_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   result_q;
  logic                res_carry_q;
  logic [2*DATA_W-1:0] prod_q;
  logic [CW-1:0]       cnt_q;

  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] prod_next;

  alu_comb #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .opcode (op_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Multiplier sits in the low half and is shifted out as the partial product grows in the high half.
  assign mul_sum   = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + {1'b0, a_q};
  assign prod_next = prod_q[0] ? {mul_sum, prod_q[DATA_W-1:1]}
                               : {1'b0, prod_q[2*DATA_W-1:1]};

  assign instr_ready = (state == S_IDLE);
  assign busy        = !instr_ready;
  assign rd          = (state == S_READ);
  assign addr1       = rd ? src1_q : '0;
  assign addr2       = rd ? src2_q : '0;
  assign wr          = (state == S_WB);
  assign wr_addr     = wr ? dst_q : '0;
  assign data_in     = wr ? result_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= '0;
      dst_q       <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      res_carry_q <= 1'b0;
      prod_q      <= '0;
      cnt_q       <= '0;
      zero        <= 1'b0;
      carry       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q   <= opcode;
            dst_q  <= dst;
            src1_q <= src1;
            src2_q <= src2;
            state  <= S_READ;
          end
        end
        S_READ: begin
          a_q   <= data_out1;
          b_q   <= data_out2;
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (op_q)
            OP_MUL: begin
              prod_q <= {{DATA_W{1'b0}}, b_q};
              cnt_q  <= '0;
              state  <= S_MUL;
            end
            OP_NOP: state <= S_IDLE;
            OP_MOV: begin
              result_q    <= alu_result;
              res_carry_q <= carry;
              state       <= S_WB;
            end
            default: begin
              result_q    <= alu_result;
              res_carry_q <= alu_carry;
              state       <= S_WB;
            end
          endcase
        end
        S_MUL: begin
          prod_q <= prod_next;
          if (cnt_q == CW'(DATA_W - 1)) begin
            result_q    <= prod_next[DATA_W-1:0];
            res_carry_q <= |prod_next[2*DATA_W-1:DATA_W];
            state       <= S_WB;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WB: begin
          zero  <= (result_q == '0);
          carry <= res_carry_q;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - directed and randomized bench for exec_stage with a register-file model
module tb_exec_stage;
  import proc_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    opcode;
  logic [AW-1:0] dst, src1, src2;
  logic [AW-1:0] addr1, addr2, wr_addr;
  logic          rd, wr;
  logic [DW-1:0] data_out1, data_out2, data_in;
  logic          zero, carry, busy;

  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  logic [DW-1:0] rf [8];
  logic [DW-1:0] ref_regs [8];
  logic          m_zero, m_carry;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exec_stage #(.DATA_W(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .dst         (dst),
    .src1        (src1),
    .src2        (src2),
    .addr1       (addr1),
    .addr2       (addr2),
    .rd          (rd),
    .data_out1   (data_out1),
    .data_out2   (data_out2),
    .wr_addr     (wr_addr),
    .wr          (wr),
    .data_in     (data_in),
    .zero        (zero),
    .carry       (carry),
    .busy        (busy)
  );

  // Environment register file: written by the DUT, or by the bench for preloads.
  always_comb begin
    data_out1 = rd ? rf[addr1] : '0;
    data_out2 = rd ? rf[addr2] : '0;
  end

  always @(posedge clk) begin
    if (wr) rf[wr_addr] <= data_in;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = v;
    ref_regs[a] = v;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic check_idle_after_reset(input string tag);
    check({tag, ".ready"}, instr_ready, 1);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".rd"}, rd, 0);
    check({tag, ".wr"}, wr, 0);
    check({tag, ".addr1"}, addr1, 0);
    check({tag, ".addr2"}, addr2, 0);
    check({tag, ".wr_addr"}, wr_addr, 0);
    check({tag, ".data_in"}, data_in, 0);
    check({tag, ".zero"}, zero, 0);
    check({tag, ".carry"}, carry, 0);
  endtask

  // Reference model of one instruction's architectural effect.
  task automatic model_exec(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            output bit exp_wr, output logic [DW-1:0] exp_data, output logic exp_c);
    int ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    exp_wr = 1'b1;
    exp_c = 1'b0;
    r = 0;
    case (op)
      OP_ADD: begin r = ai + bi; exp_c = (r >= 256); end
      OP_SUB: begin r = (ai - bi + 256) % 256; exp_c = (ai < bi); end
      OP_AND: r = ai & bi;
      OP_OR:  r = ai | bi;
      OP_XOR: r = ai ^ bi;
      OP_MOV: begin r = ai; exp_c = m_carry; end
      OP_MUL: begin r = ai * bi; exp_c = (r >= 256); end
      default: begin exp_wr = 1'b0; exp_c = m_carry; end
    endcase
    exp_data = DW'(r % 256);
  endtask

  task automatic exec_instr(input string tag, input logic [2:0] op, input logic [AW-1:0] d,
                            input logic [AW-1:0] s1, input logic [AW-1:0] s2, input bit scramble);
    bit            exp_wr;
    logic [DW-1:0] exp_data;
    logic          exp_c;
    int            wr_cyc, rdy_cyc, n;
    n = 0;
    while (!instr_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, ".ready0"}, instr_ready, 1);
    instr_valid = 1'b1;
    opcode = op;
    dst = d;
    src1 = s1;
    src2 = s2;
    model_exec(op, ref_regs[s1], ref_regs[s2], exp_wr, exp_data, exp_c);
    wr_cyc = (op == OP_MUL) ? 3 + DW : 3;
    rdy_cyc = (op == OP_NOP) ? 3 : wr_cyc + 1;
    for (int cyc = 1; cyc <= rdy_cyc; cyc++) begin
      tick();
      if (scramble) begin
        opcode = 3'($urandom_range(0, 7));
        dst = AW'($urandom_range(0, 7));
        src1 = AW'($urandom_range(0, 7));
        src2 = AW'($urandom_range(0, 7));
      end else begin
        instr_valid = 1'b0;
      end
      check($sformatf("%s.ready@%0d", tag, cyc), instr_ready, (cyc >= rdy_cyc));
      check($sformatf("%s.busy@%0d", tag, cyc), busy, (cyc < rdy_cyc));
      check($sformatf("%s.rd@%0d", tag, cyc), rd, (cyc == 1));
      if (cyc == 1) begin
        check({tag, ".addr1"}, addr1, s1);
        check({tag, ".addr2"}, addr2, s2);
      end
      check($sformatf("%s.wr@%0d", tag, cyc), wr, (exp_wr && cyc == wr_cyc));
      if (exp_wr && cyc == wr_cyc) begin
        check({tag, ".wr_addr"}, wr_addr, d);
        check({tag, ".data_in"}, data_in, exp_data);
      end else begin
        check($sformatf("%s.idle_data@%0d", tag, cyc), data_in, 0);
        check($sformatf("%s.idle_waddr@%0d", tag, cyc), wr_addr, 0);
      end
    end
    if (exp_wr) begin
      ref_regs[d] = exp_data;
      m_zero = (exp_data == '0);
      m_carry = exp_c;
    end
    check({tag, ".zero"}, zero, m_zero);
    check({tag, ".carry"}, carry, m_carry);
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    opcode = '0;
    dst = '0;
    src1 = '0;
    src2 = '0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    m_zero = 1'b0;
    m_carry = 1'b0;
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    tick();
    for (int i = 0; i < 8; i++) preload(AW'(i), '0);
    rst = 1'b0;
    check_idle_after_reset("reset");

    preload(3'd1, 8'd200);
    preload(3'd2, 8'd100);
    exec_instr("add", OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0);
    check("add.rf3", ref_regs[3], 8'd44);

    preload(3'd4, 8'd5);
    exec_instr("sub", OP_SUB, 3'd5, 3'd4, 3'd4, 1'b0);

    preload(3'd1, 8'd16);
    preload(3'd2, 8'd20);
    exec_instr("mul", OP_MUL, 3'd6, 3'd1, 3'd2, 1'b0);
    exec_instr("nop", OP_NOP, 3'd0, 3'd1, 3'd2, 1'b0);

    // Abandon a multiply with reset in cycle 5.
    instr_valid = 1'b1;
    opcode = OP_MUL;
    dst = 3'd7;
    src1 = 3'd1;
    src2 = 3'd2;
    tick();
    instr_valid = 1'b0;
    for (int c = 2; c <= 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_zero = 1'b0;
    m_carry = 1'b0;
    check_idle_after_reset("mul_rst");
    for (int c = 0; c < 16; c++) begin
      tick();
      check($sformatf("mul_rst.nowr@%0d", c), wr, 0);
    end

    // Reset wins over a simultaneous accept.
    rst = 1'b1;
    instr_valid = 1'b1;
    opcode = OP_ADD;
    tick();
    rst = 1'b0;
    instr_valid = 1'b0;
    check("rst_prio.ready", instr_ready, 1);
    check("rst_prio.rd", rd, 0);
    tick();
    check("rst_prio.rd2", rd, 0);

    preload(3'd1, 8'd7);
    preload(3'd2, 8'd9);
    preload(3'd3, 8'h30);
    preload(3'd4, 8'h05);
    exec_instr("hold1", OP_ADD, 3'd7, 3'd1, 3'd2, 1'b1);
    exec_instr("hold2", OP_OR, 3'd0, 3'd3, 3'd4, 1'b0);
    check("hold.rf7", ref_regs[7], 8'd16);

    for (int i = 0; i < 8; i++) preload(AW'(i), DW'($urandom_range(0, 255)));
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) preload(AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)));
      exec_instr($sformatf("rnd%0d", k), 3'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), 1'b0);
    end
    for (int i = 0; i < 8; i++) check($sformatf("final.rf%0d", i), rf[i], ref_regs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
